// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package mem_stage_sram_ctrl_pkg;

  localparam int unsigned DATA_MEM_BASE = 1024;
  localparam int unsigned SRAM_ADDR_W   = 18;
  localparam int unsigned SRAM_DATA_W   = 16;
  localparam int unsigned CNT_W         = 4;
  localparam int unsigned WORD_W        = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  // Halfword SRAM address from a word index and the half being accessed.
  function automatic logic [SRAM_ADDR_W-1:0] sram_half_addr(
    input logic [SRAM_ADDR_W-2:0] word_idx,
    input logic                   half
  );
    return {word_idx, half};
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_sram_wait_counter.sv
// Wait-state counter: counts SRAM cycles within one halfword access.
module sram_wait_counter
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term_c
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Clear has priority so the terminal cycle restarts the count for the next half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign term_c = (cnt == TERM_VAL);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller splitting 32-bit loads/stores into two 16-bit SRAM halfword accesses.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'(DATA_MEM_BASE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [WORD_W-1:0]      ALU_result,
  input  logic [WORD_W-1:0]      ST_val,
  output logic [WORD_W-1:0]      read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  mem_state_e             state;
  logic                   is_write;
  logic [SRAM_DATA_W-1:0] lo_half;
  logic                   term_c;
  logic                   req_c;
  logic                   in_access_c;
  logic [WORD_W-1:0]      off_c;
  logic [SRAM_ADDR_W-2:0] word_idx_c;
  logic                   unused_off_bits;
  logic                   dq_oe_c;
  logic [SRAM_DATA_W-1:0] dq_out_c;

  assign req_c       = MEM_R_EN | MEM_W_EN;
  assign in_access_c = (state == LOW) || (state == HIGH);

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk    (clk),
    .rst_n  (rst),
    .clr    (!in_access_c || term_c),
    .en     (in_access_c),
    .term_c (term_c)
  );

  // Access type is frozen on leaving IDLE; a store wins when both requests are high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      lo_half   <= '0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_c) begin
            state    <= LOW;
            is_write <= MEM_W_EN;
          end
        end
        LOW: begin
          if (term_c) begin
            state <= HIGH;
            if (!is_write) lo_half <= SRAM_DQ;
          end
        end
        HIGH: begin
          if (term_c) begin
            state <= DONE;
            if (!is_write) read_data <= {SRAM_DQ, lo_half};
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = ((state == IDLE) && !req_c) || (state == DONE);

  // Address and store data follow the (frozen) EX/MEM inputs live.
  assign off_c           = ALU_result - BASE_ADDR;
  assign word_idx_c      = off_c[SRAM_ADDR_W:2];
  assign unused_off_bits = ^{off_c[WORD_W-1:SRAM_ADDR_W+1], off_c[1:0]};

  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_oe_c   = 1'b0;
    dq_out_c  = '0;
    case (state)
      LOW: begin
        SRAM_ADDR = sram_half_addr(word_idx_c, 1'b0);
        SRAM_WE_N = !is_write;
        dq_oe_c   = is_write;
        dq_out_c  = ST_val[SRAM_DATA_W-1:0];
      end
      HIGH: begin
        SRAM_ADDR = sram_half_addr(word_idx_c, 1'b1);
        SRAM_WE_N = !is_write;
        dq_oe_c   = is_write;
        dq_out_c  = ST_val[WORD_W-1:SRAM_DATA_W];
      end
      default: ;
    endcase
  end

  assign SRAM_DQ   = dq_oe_c ? dq_out_c : {SRAM_DATA_W{1'bz}};
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a small halfword SRAM model on a pulled-up bus.
module tb_mem_stage_sram_ctrl;

  localparam int unsigned W    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] st_val = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] dq_bus;
  logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  logic [15:0] sram_mem [0:255];
  logic        sram_oe = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(
    .WAIT_CYCLES (W),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (mem_r_en),
    .MEM_W_EN   (mem_w_en),
    .ALU_result (alu_result),
    .ST_val     (st_val),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_ADDR  (sram_addr),
    .SRAM_DQ    (dq_bus),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_UB_N  (sram_ub_n),
    .SRAM_LB_N  (sram_lb_n),
    .SRAM_CE_N  (sram_ce_n),
    .SRAM_OE_N  (sram_oe_n)
  );

  // Undriven bus reads as all ones, which exposes any DUT drive during reads/idle.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (dq_bus[i]);
  end

  assign dq_bus = (sram_oe && sram_we_n) ? sram_mem[sram_addr[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr[7:0]] <= dq_bus;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full access from IDLE; checks every cycle 0..2W+1. Returns #1 after the edge leaving DONE.
  task automatic run_access(input string tag, input logic r, input logic w,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] rd_exp, input bit flip);
    logic [31:0] off;
    logic [17:0] lo_a, hi_a;
    off  = addr - BASE;
    lo_a = {off[18:2], 1'b0};
    hi_a = {off[18:2], 1'b1};
    mem_r_en   = r;
    mem_w_en   = w;
    alu_result = addr;
    st_val     = data;
    for (int c = 0; c <= 2*W+1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check($sformatf("%s_c%0d_ready", tag, c), 32'(ready), 32'd0);
        check($sformatf("%s_c%0d_addr", tag, c), 32'(sram_addr), 32'd0);
      end else if (c <= 2*W) begin
        check($sformatf("%s_c%0d_ready", tag, c), 32'(ready), 32'd0);
        check($sformatf("%s_c%0d_addr", tag, c), 32'(sram_addr),
              32'((c <= W) ? lo_a : hi_a));
        check($sformatf("%s_c%0d_we_n", tag, c), 32'(sram_we_n), 32'(!w));
        if (w)
          check($sformatf("%s_c%0d_dq", tag, c), 32'(dq_bus),
                32'((c <= W) ? data[15:0] : data[31:16]));
        else if (!sram_oe)
          check($sformatf("%s_c%0d_dq_z", tag, c), 32'(dq_bus), 32'h0000_ffff);
      end else begin
        check($sformatf("%s_done_ready", tag), 32'(ready), 32'd1);
        check($sformatf("%s_done_addr", tag), 32'(sram_addr), 32'd0);
        check($sformatf("%s_done_we_n", tag), 32'(sram_we_n), 32'd1);
        check($sformatf("%s_done_rdata", tag), read_data, rd_exp);
      end
      @(posedge clk);
      #1;
      if (flip && c == 1) begin
        mem_r_en = w;
        mem_w_en = r;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = 16'h0000;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_dq_z", 32'(dq_bus), 32'h0000_ffff);
    check("rst_ties", 32'({sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    run_access("wr1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'd0, 1'b0);
    check("wr1028_mem2", 32'(sram_mem[2]), 32'h0000_beef);
    check("wr1028_mem3", 32'(sram_mem[3]), 32'h0000_dead);

    sram_mem[2] = 16'hBEEF;
    sram_mem[3] = 16'hDEAD;
    sram_oe = 1'b1;
    run_access("rd1028", 1'b1, 1'b0, 32'd1028, 32'd0, 32'hDEADBEEF, 1'b0);

    // Inputs switch to a store mid-access; the latched read must still complete as a read
    run_access("rdflip", 1'b1, 1'b0, 32'd1028, 32'h11112222, 32'hDEADBEEF, 1'b1);
    check("rdflip_mem2", 32'(sram_mem[2]), 32'h0000_beef);
    check("rdflip_mem3", 32'(sram_mem[3]), 32'h0000_dead);

    sram_oe = 1'b0;
    run_access("rdz", 1'b1, 1'b0, 32'd1036, 32'd0, 32'hFFFFFFFF, 1'b0);

    run_access("b2b_wr", 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0);
    sram_oe = 1'b1;
    run_access("b2b_rd", 1'b1, 1'b0, 32'd1032, 32'd0, 32'hCAFEF00D, 1'b0);
    check("b2b_mem4", 32'(sram_mem[4]), 32'h0000_f00d);
    check("b2b_mem5", 32'(sram_mem[5]), 32'h0000_cafe);

    sram_oe  = 1'b0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("idle_c%0d_ready", c), 32'(ready), 32'd1);
      check($sformatf("idle_c%0d_we_n", c), 32'(sram_we_n), 32'd1);
      check($sformatf("idle_c%0d_dq_z", c), 32'(dq_bus), 32'h0000_ffff);
      check($sformatf("idle_c%0d_rdata", c), read_data, 32'hCAFEF00D);
    end
    @(posedge clk);
    #1;

    run_access("both", 1'b1, 1'b1, 32'd1024, 32'h12345678, 32'hCAFEF00D, 1'b0);
    check("both_mem0", 32'(sram_mem[0]), 32'h0000_5678);
    check("both_mem1", 32'(sram_mem[1]), 32'h0000_1234);

    sram_oe = 1'b1;
    run_access("rd1024", 1'b1, 1'b0, 32'd1024, 32'd0, 32'h12345678, 1'b0);

    // Reset asserted during the HIGH half of a store
    sram_oe    = 1'b0;
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b1;
    alu_result = 32'd1040;
    st_val     = 32'h0BADF00D;
    repeat (W + 1) @(posedge clk);
    @(negedge clk);
    check("rsthi_pre_we_n", 32'(sram_we_n), 32'd0);
    check("rsthi_pre_dq", 32'(dq_bus), 32'h0000_0bad);
    #1 rst = 1'b0;
    #1;
    check("rsthi_we_n", 32'(sram_we_n), 32'd1);
    check("rsthi_dq_z", 32'(dq_bus), 32'h0000_ffff);
    check("rsthi_addr", 32'(sram_addr), 32'd0);
    check("rsthi_rdata", read_data, 32'd0);
    mem_w_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rsthi_post_ready", 32'(ready), 32'd1);
    check("rsthi_post_rdata", read_data, 32'd0);
    check("rsthi_post_we_n", 32'(sram_we_n), 32'd1);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
